// File: rtl/fxp_pkg.sv
// Shared fixed-point format helpers: format legality, saturation bounds and
// the rounding shift between two Q formats.
package fxp_pkg;

   function automatic bit fmt_ok(input int din_w, input int din_f,
                                 input int dout_w, input int dout_f);
      return (dout_f >= 0) && (dout_w >= 2) && (dout_f <= din_f) &&
             ((dout_w - dout_f) <= (din_w - din_f)) && (din_w <= 62);
   endfunction

   function automatic int fxp_shift(input int din_f, input int dout_f);
      return din_f - dout_f;
   endfunction

   function automatic longint sat_max(input int w);
      return (longint'(1) <<< (w - 1)) - longint'(1);
   endfunction

   function automatic longint sat_min(input int w);
      return -(longint'(1) <<< (w - 1));
   endfunction

endpackage

// File: rtl/fxp_pipe_slice.sv
// Single-entry valid/ready register slice; loads when empty or when the
// downstream side is taking the held word this cycle.
module fxp_pipe_slice #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   logic         v;
   logic [W-1:0] d;

   assign in_ready  = !v | out_ready;
   assign out_valid = v;
   assign out_data  = d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v <= 1'b0;
         d <= '0;
      end else if (in_ready) begin
         v <= in_valid;
         if (in_valid) d <= in_data;
      end
   end

endmodule

// File: rtl/fxp_requantizer.sv
// Two-stage round-half-up / saturate requantizer with overflow flag pass-through
// and sticky/counted overflow status for the control interface.
module fxp_requantizer
   import fxp_pkg::*;
#(
   parameter int DIN_WIDTH  = 32,
   parameter int DIN_FRAC   = 24,
   parameter int DOUT_WIDTH = 16,
   parameter int DOUT_FRAC  = 12,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_valid,
   output logic                  s_ready,
   input  logic [DIN_WIDTH-1:0]  s_data,
   input  logic                  s_ovr,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DOUT_WIDTH-1:0] m_data,
   output logic                  m_ovr,
   input  logic                  clr,
   output logic                  ovr_sticky,
   output logic [CNT_WIDTH-1:0]  ovr_count
);

   localparam int SHIFT = fxp_shift(DIN_FRAC, DOUT_FRAC);
   localparam int RW    = DIN_WIDTH + 1;
   localparam int W1    = RW + 2;
   localparam int W2    = DOUT_WIDTH + 1;

   localparam logic signed [RW-1:0] R_MAX = RW'(sat_max(DOUT_WIDTH));
   localparam logic signed [RW-1:0] R_MIN = RW'(sat_min(DOUT_WIDTH));
   localparam logic [DOUT_WIDTH-1:0] Q_MAX = DOUT_WIDTH'(sat_max(DOUT_WIDTH));
   localparam logic [DOUT_WIDTH-1:0] Q_MIN = DOUT_WIDTH'(sat_min(DOUT_WIDTH));

   if (!fmt_ok(DIN_WIDTH, DIN_FRAC, DOUT_WIDTH, DOUT_FRAC)) begin : g_fmt_err
      $error("fxp_requantizer: output format does not fit inside input format");
   end

   logic signed [RW-1:0] s_ext;
   logic signed [RW-1:0] r_round;

   assign s_ext = {s_data[DIN_WIDTH-1], s_data};

   // One extra bit of headroom keeps the half-LSB add from wrapping at +max.
   if (SHIFT > 0) begin : g_round
      localparam logic signed [RW-1:0] HALF = RW'(1) <<< (SHIFT - 1);
      logic signed [RW-1:0] sum;
      assign sum     = s_ext + HALF;
      assign r_round = sum >>> SHIFT;
   end else begin : g_noround
      assign r_round = s_ext;
   end

   logic              st1_ready;
   logic              st1_valid;
   logic              st2_ready;
   logic [W1-1:0]     st1_out;
   logic [W2-1:0]     st2_in;
   logic [W2-1:0]     st2_out;

   assign s_ready = rst_n & st1_ready;

   // The original sign travels with r so a flagged sample clamps by its true
   // sign even when rounding has pulled a small negative value up to zero.
   fxp_pipe_slice #(.W(W1)) u_stage1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (s_valid),
      .in_ready  (st1_ready),
      .in_data   ({s_data[DIN_WIDTH-1], r_round, s_ovr}),
      .out_valid (st1_valid),
      .out_ready (st2_ready),
      .out_data  (st1_out)
   );

   logic                  msb1;
   logic                  ovr1;
   logic signed [RW-1:0]  r1;
   logic [DOUT_WIDTH-1:0] q2;
   logic                  sat2;

   assign msb1 = st1_out[W1-1];
   assign r1   = st1_out[RW:1];
   assign ovr1 = st1_out[0];

   always_comb begin
      q2   = r1[DOUT_WIDTH-1:0];
      sat2 = 1'b0;
      if (ovr1) begin
         q2 = msb1 ? Q_MIN : Q_MAX;
      end else if (r1 > R_MAX) begin
         q2   = Q_MAX;
         sat2 = 1'b1;
      end else if (r1 < R_MIN) begin
         q2   = Q_MIN;
         sat2 = 1'b1;
      end
   end

   assign st2_in = {q2, ovr1 | sat2};

   fxp_pipe_slice #(.W(W2)) u_stage2 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (st1_valid),
      .in_ready  (st2_ready),
      .in_data   (st2_in),
      .out_valid (m_valid),
      .out_ready (m_ready),
      .out_data  (st2_out)
   );

   assign m_data = st2_out[W2-1:1];
   assign m_ovr  = st2_out[0];

   logic ovr_hs;
   assign ovr_hs = m_valid & m_ready & m_ovr;

   // A counted handshake coinciding with clr survives the clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovr_sticky <= 1'b0;
         ovr_count  <= '0;
      end else if (clr) begin
         ovr_sticky <= ovr_hs;
         ovr_count  <= CNT_WIDTH'(ovr_hs);
      end else if (ovr_hs) begin
         ovr_sticky <= 1'b1;
         if (ovr_count != {CNT_WIDTH{1'b1}}) ovr_count <= ovr_count + CNT_WIDTH'(1);
      end
   end

endmodule
